// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WORDS  = 16;
  localparam int unsigned OFF_W  = 4;

  // Word i of a line sits at bits [32*i +: 32], matching the memory block layout.
  typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] word_sel(input line_t line, input logic [OFF_W-1:0] off);
    return line[off];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus bundles for dcache_ctrl.
interface dcache_cpu_if #(parameter int unsigned ADDR_W = 32);
  import dcache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_stall;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, cpu_stall);
  modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, cpu_stall);
endinterface

interface dcache_mem_if #(parameter int unsigned ADDR_W = 32);
  import dcache_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  line_t             mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_array.sv
// Tag, valid and data storage: combinational read, synchronous fill / word write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int unsigned LINES = 64,
  parameter int unsigned TAG_W = 22,
  localparam int unsigned INDEX_W = $clog2(LINES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output line_t              rd_line,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  line_t              fill_line,
  input  logic               word_en,
  input  logic [OFF_W-1:0]   word_off,
  input  logic [WORD_W-1:0]  word_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [LINES];
  line_t            data_mem [LINES];

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_mem[index];
  assign rd_line  = data_mem[index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end
  end

  // Arrays keep their contents across reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_en) begin
        data_mem[index] <= fill_line;
        tag_mem[index]  <= fill_tag;
      end else if (word_en) begin
        data_mem[index][word_off] <= word_data;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned LINES  = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  dcache_cpu_if.slave  cpu,
  dcache_mem_if.master mem,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_W - INDEX_W - OFF_W;

  state_t              state_q, state_d;
  logic                done_q, done_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                hit_inc, miss_inc, fill_en, word_en;

  logic [OFF_W-1:0]    off;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;
  logic                rd_valid, hit;
  logic [TAG_W-1:0]    rd_tag;
  line_t               rd_line;

  assign off   = cpu.cpu_addr[OFF_W-1:0];
  assign index = cpu.cpu_addr[OFF_W +: INDEX_W];
  assign tag   = cpu.cpu_addr[ADDR_W-1 -: TAG_W];
  assign hit   = cpu.cpu_req & rd_valid & (rd_tag == tag);

  dcache_array #(.LINES(LINES), .TAG_W(TAG_W)) u_array (
    .clk       (clk),
    .reset     (reset),
    .index     (index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .fill_en   (fill_en),
    .fill_tag  (tag),
    .fill_line (mem.mem_rdata),
    .word_en   (word_en),
    .word_off  (off),
    .word_data (cpu.cpu_wdata)
  );

  // done_q marks the single release cycle after a transaction so it is neither reissued nor counted.
  assign cpu.cpu_stall = (state_q != IDLE) | (cpu.cpu_req & (~hit | cpu.cpu_we) & ~done_q);
  assign cpu.cpu_rdata = (state_q == IDLE && hit && !cpu.cpu_we) ? word_sel(rd_line, off) : '0;

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    fill_en     = 1'b0;
    word_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu.cpu_req && !done_q) begin
          if (cpu.cpu_we) begin
            word_en     = hit;
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = cpu.cpu_addr;
            mem_wdata_d = cpu.cpu_wdata;
          end else if (hit) begin
            hit_inc = 1'b1;
          end else begin
            miss_inc   = 1'b1;
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag, index, OFF_W'(0)};
          end
        end
      end
      FILL: begin
        if (mem.mem_ready) begin
          fill_en   = 1'b1;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
        end
      end
      WRITE: begin
        if (mem.mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (hit_inc && hit_count != '1) hit_count <= hit_count + 32'd1;
      if (miss_inc && miss_count != '1) miss_count <= miss_count + 32'd1;
    end
  end

endmodule
